rpc2_ctrl_ax_fifo_stat: RTL
===========================

Name: rpc2_ctrl_ax_fifo_stat

Overview:
Parametrised synchronous FIFO for the RPC2 controller AXI address/data paths. It is the successor of the controller's basic single-clock FIFO and adds:
- full, almost-full and almost-empty flags
- an occupancy count
- a synchronous flush
Single clock domain; it sits between the AXI slave front-end and the RPC2 transaction sequencer.

Parameters:
ADDR_BITS, 4, log2 of depth; depth DEPTH = 2**ADDR_BITS; legal range 1..12; elaboration error outside.
DATA_WIDTH, 16, width of each entry in bits.
AFULL_THRESH, 12, almost_full asserted when occupancy >= this value; legal 1..DEPTH.
AEMPTY_THRESH, 2, almost_empty asserted when occupancy <= this value; legal 0..DEPTH-1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of FIFO contents
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_data  output  DATA_WIDTH  read data, registered
full  output  1  no free entry
empty  output  1  no valid entry
almost_full  output  1  occupancy >= AFULL_THRESH
almost_empty  output  1  occupancy <= AEMPTY_THRESH
count  output  ADDR_BITS+1  current occupancy, 0..DEPTH

Behaviour:
- Reset values: rd_data=0, full=0, empty=1, almost_full=0, almost_empty=1, count=0. Both pointers are reset to 0.
- Pointers are ADDR_BITS+1 bits wide. Memory index is the low ADDR_BITS bits. The MSB distinguishes full from empty. Pointers wrap modulo 2**(ADDR_BITS+1) with no special case.
- wr_accept = wr_en & ~full & ~flush. rd_accept = rd_en & ~empty & ~flush.
- A write to a full FIFO is dropped, even if a read is accepted in the same cycle. A read from an empty FIFO is ignored, even if a write is accepted in the same cycle.
- Read latency is 1. rd_data updates on the clock edge after rd_accept with mem[rd_ptr]. It holds its value otherwise, including through flush.
- Write data is stored at the rising edge on which wr_accept is true. It is readable no earlier than the following cycle; there is no fall-through.
- Next occupancy is cnt_nxt = count + wr_accept - rd_accept, computed at ADDR_BITS+1 bits.
- All flags and count are registered from cnt_nxt, so they are valid in the same cycle as the pointers:
  - empty = (cnt_nxt == 0)
  - full = (cnt_nxt == DEPTH)
  - almost_full = (cnt_nxt >= AFULL_THRESH)
  - almost_empty = (cnt_nxt <= AEMPTY_THRESH)
- Simultaneous accepted read and write: count and all flags are unchanged.
- flush has priority over rd_en and wr_en. On the next edge: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0. Memory contents are not cleared.
- Asynchronous reset mid-operation forces all reset values immediately. The previous contents are lost logically.
- No combinational path from any input to any output.

Optional Feature:
Macro: RPC2_CTRL_AX_FIFO_ERR_EN.
- Defined: adds two output ports, overflow and underflow, each 1 bit, reset 0.
  - overflow is a sticky flag set on the edge after wr_en & full & ~flush.
  - underflow is a sticky flag set on the edge after rd_en & empty & ~flush.
  - Both flags are cleared only by flush or rst_n. flush clears them even if an error condition occurs in the same cycle.
- Undefined: the ports and their logic are absent. Dropped writes and ignored reads are silent.

Decomposition:
- Shared package/header rpc2_ctrl_fifo_pkg holds:
  - the parameter-range check macros
  - a clog2 helper function
  - localparams for the default AXI AW/W FIFO sizes.
- One sub-module, rpc2_ctrl_fifo_mem: a simple dual-port array with registered read port (wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data). It isolates a later swap to a vendor RAM macro.
- Pointer, count and flag logic stay in the top module.

Test Plan:
1. Reset then idle: after rst_n release, check empty=1, almost_empty=1, count=0, rd_data=0. rd_en=1 for 3 cycles leaves all outputs unchanged.
2. Fill with defaults, writing 16 words 0x0000..0x000F back-to-back:
   - almost_empty drops after the 3rd write.
   - almost_full rises after the 12th write.
   - full=1 and count=16 after the 16th write.
   - A 17th write of 0xDEAD is dropped, and count stays 16.
3. Drain: 16 reads return 0x0000..0x000F in order, each one cycle after its rd_en. empty=1 after the 16th read. A further rd_en leaves rd_data=0x000F.
4. Simultaneous read/write:
   - At count=5, wr_en and rd_en together for 40 cycles: count stays 5, and data order is preserved across pointer wrap.
   - At count=16: write dropped, read accepted, count becomes 15.
   - At count=0: read ignored, write accepted, count becomes 1.
5. Flush: at count=9, assert flush together with wr_en and rd_en. Next cycle count=0, empty=1, rd_data unchanged. A subsequent write of 0x1234 then a read returns 0x1234.
6. With RPC2_CTRL_AX_FIFO_ERR_EN:
   - A write while full sets overflow; a read while empty sets underflow.
   - Both flags stay set through normal traffic and clear one cycle after flush.
   - Mid-fill rst_n pulse: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rpc2_ctrl_fifo_pkg.sv
// Shared RPC2 controller FIFO definitions: parameter range checks,
// clog2 helper and default AXI AW/W FIFO sizing.
`ifndef RPC2_CTRL_FIFO_PKG_SV
`define RPC2_CTRL_FIFO_PKG_SV

`define RPC2_FIFO_CHECK_RANGE(LBL, VAL, LO, HI) \
  if (((VAL) < (LO)) || ((VAL) > (HI))) begin : LBL \
    $error("rpc2 fifo: parameter %0d outside %0d..%0d", \
           (VAL), (LO), (HI)); \
  end

package rpc2_ctrl_fifo_pkg;

  localparam int AX_AW_FIFO_ADDR_BITS = 2;
  localparam int AX_AW_FIFO_WIDTH     = 48;
  localparam int AX_W_FIFO_ADDR_BITS  = 4;
  localparam int AX_W_FIFO_WIDTH      = 18;

  localparam int FIFO_ADDR_BITS_MIN = 1;
  localparam int FIFO_ADDR_BITS_MAX = 12;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/rpc2_ctrl_fifo_mem.sv
// Simple dual-port FIFO storage with a registered read port.
// Kept separate so a vendor RAM macro can replace it.
module rpc2_ctrl_fifo_mem
  import rpc2_ctrl_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rpc2_ctrl_ax_fifo_stat.sv
// RPC2 AXI path FIFO with occupancy count, status flags and flush.
// RPC2_CTRL_AX_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module rpc2_ctrl_ax_fifo_stat
  import rpc2_ctrl_fifo_pkg::*;
#(
  parameter int ADDR_BITS     = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    count
`ifdef RPC2_CTRL_AX_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;

  `RPC2_FIFO_CHECK_RANGE(g_chk_addr_bits, ADDR_BITS,
                         FIFO_ADDR_BITS_MIN, FIFO_ADDR_BITS_MAX)
  `RPC2_FIFO_CHECK_RANGE(g_chk_afull, AFULL_THRESH, 1, DEPTH)
  `RPC2_FIFO_CHECK_RANGE(g_chk_aempty, AEMPTY_THRESH, 0, DEPTH - 1)

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_TH   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_TH   = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] ONE     = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          wr_acc;
  logic          rd_acc;

  assign wr_acc = wr_en & ~full_q & ~flush;
  assign rd_acc = rd_en & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      cnt_d = cnt_q + {{ADDR_BITS{1'b0}}, wr_acc}
                    - {{ADDR_BITS{1'b0}}, rd_acc};
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_C);
    af_d    = (cnt_d >= AF_TH);
    ae_d    = (cnt_d <= AE_TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  rpc2_ctrl_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_BITS-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q[ADDR_BITS-1:0]),
    .rd_data (rd_data)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = cnt_q;

`ifdef RPC2_CTRL_AX_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Flush wins over an error raised in the same cycle.
  always_comb begin
    ovf_d = ovf_q | (wr_en & full_q);
    udf_d = udf_q | (rd_en & empty_q);
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule
